// File: rtl/line_buffer_v_window_fp16_pkg.sv
// Shared types and constants for the fp16 vertical line-buffer window generator.
package line_buffer_v_window_fp16_pkg;

    localparam int EXP_WIDTH_DEF     = 5;
    localparam int FRAC_WIDTH_DEF    = 10;
    localparam int FP_WIDTH_DEF      = 1 + EXP_WIDTH_DEF + FRAC_WIDTH_DEF;
    localparam int WINDOW_HEIGHT_DEF = 9;

    typedef logic [FP_WIDTH_DEF-1:0] fp_word_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        FLUSH
    } lb_state_t;

    // Rows between the window centre and either window edge.
    function automatic int half_window(input int height);
        return (height - 1) / 2;
    endfunction

endpackage

// File: rtl/line_buffer_v_window_fp16_line_ram.sv
// One previous image line: IMAGE_WIDTH-deep RAM with a registered read port and an independent write port.
module line_ram_sp #(
    parameter int DEPTH  = 640,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/line_buffer_v_window_fp16.sv
// Vertical WINDOW_HEIGHT x 1 window generator over a raster fp16 stream.
// Define LINE_BUFFER_V_ZERO_PAD_EN for same-size output with zero padding and a bottom flush.
module line_buffer_v_window_fp16
    import line_buffer_v_window_fp16_pkg::*;
#(
    parameter int EXP_WIDTH     = EXP_WIDTH_DEF,
    parameter int FRAC_WIDTH    = FRAC_WIDTH_DEF,
    parameter int WINDOW_HEIGHT = WINDOW_HEIGHT_DEF,
    parameter int IMAGE_WIDTH   = 640,
    parameter int IMAGE_HEIGHT  = 480,
    parameter int FP_WIDTH_REG  = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [FP_WIDTH_REG-1:0] pixel_i,
    input  logic [15:0]             col_i,
    input  logic [15:0]             row_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [FP_WIDTH_REG-1:0] window_o [WINDOW_HEIGHT][1],
    output logic [15:0]             col_o,
    output logic [15:0]             row_o,
    output logic                    valid_o
);

    localparam int          NUM_LINES = WINDOW_HEIGHT - 1;
    localparam int          HALF      = half_window(WINDOW_HEIGHT);
    localparam int          ADDR_W    = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam logic [15:0] LAST_COL  = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] LAST_ROW  = 16'(IMAGE_HEIGHT - 1);

    lb_state_t               state;
    logic [15:0]             fill;
    logic                    acc_vld;
    logic [15:0]             acc_col;
    logic [15:0]             acc_row;
    logic [FP_WIDTH_REG-1:0] acc_pix;
    logic                    frame_start;
    logic                    qual;

`ifdef LINE_BUFFER_V_ZERO_PAD_EN
    logic [15:0] flush_col;
    logic [15:0] flush_line;

    // During FLUSH the bottom padding lines are injected as zero pixels below the last image row.
    always_comb begin
        acc_vld = valid_i && ready_o;
        acc_col = col_i;
        acc_row = row_i;
        acc_pix = pixel_i;
        if (state == FLUSH) begin
            acc_vld = 1'b1;
            acc_col = flush_col;
            acc_row = 16'(IMAGE_HEIGHT) + flush_line;
            acc_pix = '0;
        end
    end

    assign qual = acc_vld && (state != IDLE) && (acc_row >= 16'(HALF));

    drop_in_flush: assert property (@(posedge clk_i) disable iff (!rst_i) !(valid_i && !ready_o));
`else
    assign ready_o = 1'b1;
    assign acc_vld = valid_i;
    assign acc_col = col_i;
    assign acc_row = row_i;
    assign acc_pix = pixel_i;
    assign qual    = acc_vld && (state == STREAM) && (acc_row >= 16'(NUM_LINES));
`endif

    assign frame_start = acc_vld && (acc_row == 16'd0) && (acc_col == 16'd0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            fill  <= '0;
`ifdef LINE_BUFFER_V_ZERO_PAD_EN
            ready_o    <= 1'b1;
            flush_col  <= '0;
            flush_line <= '0;
`endif
        end else if (frame_start) begin
            state <= FILL;
            fill  <= '0;
        end else if (acc_vld) begin
            case (state)
                FILL: begin
                    if (acc_col == LAST_COL) begin
                        fill <= fill + 16'd1;
                        if (fill == 16'(NUM_LINES - 1)) begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if ((acc_row == LAST_ROW) && (acc_col == LAST_COL)) begin
`ifdef LINE_BUFFER_V_ZERO_PAD_EN
                        state      <= FLUSH;
                        ready_o    <= 1'b0;
                        flush_col  <= '0;
                        flush_line <= '0;
`else
                        state <= IDLE;
`endif
                    end
                end
`ifdef LINE_BUFFER_V_ZERO_PAD_EN
                FLUSH: begin
                    if (flush_col == LAST_COL) begin
                        flush_col  <= '0;
                        flush_line <= flush_line + 16'd1;
                        if (flush_line == 16'(HALF - 1)) begin
                            state   <= IDLE;
                            ready_o <= 1'b1;
                        end
                    end else begin
                        flush_col <= flush_col + 16'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Stage p0: line RAM reads in flight; the pixel and its coordinates travel alongside.
    logic                    vld_p0;
    logic                    qual_p0;
    logic [15:0]             col_p0;
    logic [15:0]             row_p0;
    logic [FP_WIDTH_REG-1:0] pix_p0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_p0  <= 1'b0;
            qual_p0 <= 1'b0;
        end else begin
            vld_p0  <= acc_vld;
            qual_p0 <= qual;
        end
    end

    always_ff @(posedge clk_i) begin
        if (acc_vld) begin
            col_p0 <= acc_col;
            row_p0 <= acc_row;
            pix_p0 <= acc_pix;
        end
    end

    logic [FP_WIDTH_REG-1:0] rd_data [NUM_LINES];
    logic [FP_WIDTH_REG-1:0] wr_data [NUM_LINES];

    // Writing back the read column shifted by one line ages every stored row in place.
    for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
        if (k == NUM_LINES - 1) begin : g_newest
            assign wr_data[k] = pix_p0;
        end else begin : g_shift
            assign wr_data[k] = rd_data[k+1];
        end

        line_ram_sp #(
            .DEPTH (IMAGE_WIDTH),
            .WIDTH (FP_WIDTH_REG),
            .ADDR_W(ADDR_W)
        ) u_line (
            .clk_i    (clk_i),
            .rd_en_i  (acc_vld),
            .rd_addr_i(acc_col[ADDR_W-1:0]),
            .rd_data_o(rd_data[k]),
            .wr_en_i  (vld_p0),
            .wr_addr_i(col_p0[ADDR_W-1:0]),
            .wr_data_i(wr_data[k])
        );
    end

    logic [FP_WIDTH_REG-1:0] taps [WINDOW_HEIGHT];

    always_comb begin
        for (int k = 0; k < NUM_LINES; k++) begin
            taps[k] = rd_data[k];
        end
        taps[NUM_LINES] = pix_p0;
`ifdef LINE_BUFFER_V_ZERO_PAD_EN
        for (int k = 0; k < NUM_LINES; k++) begin
            if ((32'(k) + 32'(row_p0)) < 32'(NUM_LINES)) begin
                taps[k] = '0;
            end
        end
`endif
    end

    // Stage p1: registered window with centre-aligned coordinates.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_o <= 1'b0;
            col_o   <= '0;
            row_o   <= '0;
            for (int k = 0; k < WINDOW_HEIGHT; k++) begin
                window_o[k][0] <= '0;
            end
        end else begin
            valid_o <= qual_p0;
            if (qual_p0) begin
                col_o <= col_p0;
                row_o <= row_p0 - 16'(HALF);
                for (int k = 0; k < WINDOW_HEIGHT; k++) begin
                    window_o[k][0] <= taps[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_v_window_fp16.sv
// Directed bench for line_buffer_v_window_fp16: 9-tap window over a 12x10 fp16 ramp image.
`timescale 1ns/1ps
module tb_line_buffer_v_window_fp16;
    import line_buffer_v_window_fp16_pkg::*;

    localparam int H  = 9;
    localparam int W  = 12;
    localparam int IH = 10;

    logic        clk = 1'b0;
    logic        rst_i;
    fp_word_t    pixel_i;
    logic [15:0] col_i;
    logic [15:0] row_i;
    logic        valid_i;
    logic        ready_o;
    fp_word_t    window_o [H][1];
    logic [15:0] col_o;
    logic [15:0] row_o;
    logic        valid_o;

    always #5 clk = ~clk;

    line_buffer_v_window_fp16 #(
        .WINDOW_HEIGHT(H),
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (IH)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .pixel_i (pixel_i),
        .col_i   (col_i),
        .row_i   (row_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .window_o(window_o),
        .col_o   (col_o),
        .row_o   (row_o),
        .valid_o (valid_o)
    );

    int          n_cmp   = 0;
    int          n_fail  = 0;
    int          out_cnt = 0;
    int          base    = 0;
    logic        h_v [2];
    int          h_r [2];
    int          h_c [2];
    int          h_b [2];
    logic        first_seen;
    logic [15:0] snap_row, snap_col, snap_w0, snap_w1, snap_w8;

    // fp16 encoding of a small non-negative integer (exact below 2048).
    function automatic fp_word_t fp16_of(input int n);
        fp_word_t w;
        int       e;
        if (n == 0) return 16'h0000;
        e = 0;
        for (int i = 0; i < 11; i++) if (n >= (1 << i)) e = i;
        w[15]    = 1'b0;
        w[14:10] = 5'(e + 15);
        w[9:0]   = 10'((n << (10 - e)) & 32'h3FF);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        if (h_v[1]) begin
            chk("valid_o", 32'(valid_o), 32'd1);
            chk("row_o", 32'(row_o), 32'(h_r[1] - 4));
            chk("col_o", 32'(col_o), 32'(h_c[1]));
            for (int k = 0; k < H; k++)
                chk("window_tap", 32'(window_o[k][0]), 32'(fp16_of((h_r[1] - 8 + k) * W + h_c[1] + h_b[1])));
        end else begin
            chk("valid_o_low", 32'(valid_o), 32'd0);
        end
        if (valid_o === 1'b1) begin
            out_cnt++;
            if (!first_seen) begin
                first_seen = 1'b1;
                snap_row   = row_o;
                snap_col   = col_o;
                snap_w0    = window_o[0][0];
                snap_w1    = window_o[1][0];
                snap_w8    = window_o[8][0];
            end
        end
    endtask

    task automatic step(input logic v, input int r, input int c, input logic q);
        @(negedge clk);
        check_outputs();
        h_v[1] = h_v[0]; h_r[1] = h_r[0]; h_c[1] = h_c[0]; h_b[1] = h_b[0];
        h_v[0] = v && q; h_r[0] = r;      h_c[0] = c;      h_b[0] = base;
        valid_i = v;
        row_i   = v ? 16'(r) : 16'd0;
        col_i   = v ? 16'(c) : 16'd0;
        pixel_i = v ? fp16_of(r * W + c + base) : 16'hDEAD;
    endtask

    // Drives rows/cols from (r0,c0) up to (r1,c1) inclusive; q marks whether rows >= 8 should emit.
    task automatic run_span(input int r0, input int c0, input int r1, input int c1,
                            input logic gaps, input logic q);
        for (int r = r0; r <= r1; r++) begin
            for (int c = (r == r0) ? c0 : 0; c < W; c++) begin
                int g;
                if (r == r1 && c > c1) break;
                g = gaps ? int'($urandom_range(2)) : 0;
                repeat (g) step(1'b0, 0, 0, 1'b0);
                step(1'b1, r, c, q && (r >= 8));
            end
        end
    endtask

    task automatic drain();
        repeat (3) step(1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        rst_i   = 1'b0;
        valid_i = 1'b0;
        pixel_i = '0;
        col_i   = '0;
        row_i   = '0;
        for (int i = 0; i < 2; i++) begin
            h_v[i] = 1'b0; h_r[i] = 0; h_c[i] = 0; h_b[i] = 0;
        end
        first_seen = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid_o", 32'(valid_o), 32'd0);
        chk("reset_row_o", 32'(row_o), 32'd0);
        chk("reset_col_o", 32'(col_o), 32'd0);
        chk("reset_ready_o", 32'(ready_o), 32'd1);
        for (int k = 0; k < H; k++) chk("reset_tap", 32'(window_o[k][0]), 32'd0);
        rst_i = 1'b1;

        // Clean ramp frame.
        base = 0; out_cnt = 0;
        run_span(0, 0, IH - 1, W - 1, 1'b0, 1'b1);
        drain();
        chk("ramp_count", 32'(out_cnt), 32'd24);
        chk("first_row_o", 32'(snap_row), 32'd4);
        chk("first_col_o", 32'(snap_col), 32'd0);
        chk("first_tap0", 32'(snap_w0), 32'h0000);
        chk("first_tap1", 32'(snap_w1), 32'h4A00);
        chk("first_tap8", 32'(snap_w8), 32'h5600);

        // Reset in the middle of row 5; the remainder of that frame must stay silent.
        out_cnt = 0;
        run_span(0, 0, 5, 5, 1'b0, 1'b1);
        #2 rst_i = 1'b0;
        #1;
        chk("midrst_valid_o", 32'(valid_o), 32'd0);
        chk("midrst_row_o", 32'(row_o), 32'd0);
        chk("midrst_col_o", 32'(col_o), 32'd0);
        chk("midrst_ready_o", 32'(ready_o), 32'd1);
        for (int k = 0; k < H; k++) chk("midrst_tap", 32'(window_o[k][0]), 32'd0);
        valid_i = 1'b0;
        for (int i = 0; i < 2; i++) h_v[i] = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        run_span(5, 6, IH - 1, W - 1, 1'b0, 1'b0);
        drain();
        chk("post_reset_silent", 32'(out_cnt), 32'd0);

        // Restart from (0,0) after reset, offset ramp.
        base = 3; out_cnt = 0;
        run_span(0, 0, IH - 1, W - 1, 1'b0, 1'b1);
        drain();
        chk("restart_count", 32'(out_cnt), 32'd24);

        // Random valid gaps.
        base = 0; out_cnt = 0;
        run_span(0, 0, IH - 1, W - 1, 1'b1, 1'b1);
        drain();
        chk("gap_count", 32'(out_cnt), 32'd24);

        // Truncated frame at row 6, then a fresh frame with different pixel values.
        out_cnt = 0;
        run_span(0, 0, 6, 4, 1'b0, 1'b1);
        base = 7;
        run_span(0, 0, IH - 1, W - 1, 1'b0, 1'b1);
        drain();
        chk("resync_count", 32'(out_cnt), 32'd24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
